ps2_key_mapper: RTL and testbench
=================================

Name: ps2_key_mapper

Overview:
- Keyboard front end for the tank game; upstream of the two Joystick conditioners.
- Receives PS/2 set-2 scan codes from PS2_CLK/PS2_DAT and decodes make, break and E0-extended sequences.
- Drives ten held-key level outputs (up/down/left/right/fire for P1 and P2) that replace the GPIO/switch inputs on p1_*/p2_*.
- Runs on the 25 MHz system clock (CLOCK_25).

Parameters:
- FILTER_LEN, 8, consecutive equal synchronized samples required before the filtered PS/2 clock changes level.
- TIMEOUT, 50000, cycles without a falling PS/2 clock edge mid-frame before the frame is aborted (2 ms at 25 MHz).

Ports:
- clk  input  1  system clock, 25 MHz
- rst_n  input  1  reset, asynchronous, active-low
- i_ps2_clk  input  1  raw PS/2 clock from pad (asynchronous)
- i_ps2_dat  input  1  raw PS/2 data from pad (asynchronous)
- o_p1_up, o_p1_down, o_p1_left, o_p1_right, o_p1_fire  output  1 each  P1 key held (W, S, A, D, Space)
- o_p2_up, o_p2_down, o_p2_left, o_p2_right, o_p2_fire  output  1 each  P2 key held (arrows, Enter)
- o_scan_code  output  8  last correctly received byte
- o_scan_valid  output  1  one-cycle pulse: o_scan_code updated
- o_frame_err  output  1  one-cycle pulse: frame discarded

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low. Reset forces every output to 0, the FSM to IDLE, and clears the prefix flags, bit counter, filter and timeout counter. Reset mid-frame discards the partial byte.
- Input conditioning: both pad inputs pass through a 2-FF synchronizer. The filtered clock changes only after FILTER_LEN identical synchronized samples. A falling edge of the filtered clock is the sample strobe, and data is sampled from the synchronized data line on that strobe.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: a strobe with data=0 moves to DATA with bit count 0. A strobe with data=1 is ignored, with no error.
  - DATA: 8 strobes shift data in LSB first, then move to PARITY.
  - PARITY: one strobe latches the parity bit, then moves to STOP.
  - STOP: one strobe ends the frame; the FSM returns to IDLE.
- Frame check: the frame is good when the XOR of the 8 data bits and the parity bit is 1 (odd parity) and stop=1. A good frame pulses o_scan_valid and loads o_scan_code in the cycle after the stop strobe. A bad frame pulses o_frame_err in that same cycle; no other state changes.
- Timeout: in DATA, PARITY or STOP, TIMEOUT cycles with no strobe abort the frame to IDLE and pulse o_frame_err. The counter clears on every strobe and is held at 0 in IDLE.
- Decoder (acts on each good byte):
  - 0xE0 sets the ext flag.
  - 0xF0 sets the brk flag.
  - Any other byte is looked up with the current ext flag. A matching key output is set to !brk. Both flags then clear, whether or not the byte matched.
  - Key outputs update in the same cycle as o_scan_valid.
- Key map:
  - ext=0: 0x1D P1 up, 0x1B P1 down, 0x1C P1 left, 0x23 P1 right, 0x29 P1 fire, 0x5A P2 fire.
  - ext=1: 0x75 P2 up, 0x72 P2 down, 0x6B P2 left, 0x74 P2 right, 0x5A P2 fire (keypad Enter).
  - Unmapped codes, including 0x75 with ext=0, change no output.
- Key behaviour:
  - Typematic repeat makes leave a held key at 1.
  - Keys are independent, so any combination may be held at once.
  - A break for a key that is not held leaves it 0.
- Prefix persistence: a frame error or timeout does NOT clear the ext or brk flags. The next good non-prefix byte consumes them.
- Never driven: the block does not drive the PS/2 lines (receive only; no host-to-device commands).

Test Plan:
- Frame sequence 1D, then F0 1D → o_p1_up rises 1 cycle after the first stop strobe and falls after the 1D that follows F0. o_scan_code ends at 0x1D, with exactly 3 o_scan_valid pulses.
- Frame sequence E0 75, 75, E0 F0 75 → o_p2_up goes 1 after the first 75, stays 1 after the bare 75 (keypad 8: no change), and goes 0 after the final 75. o_p1_* stay 0 throughout.
- Byte 0x29 sent with even parity → one o_frame_err pulse, no o_scan_valid, o_p1_fire stays 0. A correct 0x29 sent next sets o_p1_fire.
- Start bit plus 4 data bits, then the clock held high for 50000 cycles → o_frame_err pulses once at the timeout, FSM is back in IDLE. A following good 0x23 sets o_p1_right.
- Make 1D, 1C, 29, then E0 72 → o_p1_up, o_p1_left, o_p1_fire and o_p2_down all read 1 together. Asserting rst_n=0 mid-frame afterwards clears all outputs asynchronously. A complete frame after release decodes normally.
- Glitch of 3 cycles low on i_ps2_clk while idle → no strobe, no o_frame_err, no output change.

Source files
------------

// File: rtl/ps2_key_mapper.sv
// rtl/ps2_key_mapper.sv - PS/2 set-2 receiver and scan-code decoder driving ten held-key outputs
module ps2_key_mapper #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic       o_p1_up,
  output logic       o_p1_down,
  output logic       o_p1_left,
  output logic       o_p1_right,
  output logic       o_p1_fire,
  output logic       o_p2_up,
  output logic       o_p2_down,
  output logic       o_p2_left,
  output logic       o_p2_right,
  output logic       o_p2_fire,
  output logic [7:0] o_scan_code,
  output logic       o_scan_valid,
  output logic       o_frame_err
);
  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
  logic          dat_meta_q, dat_meta_d, dat_sync_q, dat_sync_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  state_t        state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic [9:0]    keys_q, keys_d;
  logic [7:0]    code_q, code_d;
  logic          valid_q, valid_d, err_q, err_d;
  logic          strobe;
  logic [9:0]    key_mask;

  always_comb begin
    clk_meta_d = i_ps2_clk;
    clk_sync_d = clk_meta_q;
    dat_meta_d = i_ps2_dat;
    dat_sync_d = dat_meta_q;
    filt_d     = filt_q;
    fcnt_d     = fcnt_q;
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tcnt_d     = tcnt_q;
    ext_d      = ext_q;
    brk_d      = brk_q;
    keys_d     = keys_q;
    code_d     = code_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    key_mask   = '0;

    // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
    if (clk_sync_q == filt_q) begin
      fcnt_d = '0;
    end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
      filt_d = ~filt_q;
      fcnt_d = '0;
    end else begin
      fcnt_d = fcnt_q + FW'(1);
    end
    strobe = filt_q & ~filt_d;

    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        if (strobe && !dat_sync_q) begin
          state_d  = DATA;
          bitcnt_d = '0;
        end
      end
      DATA: begin
        if (strobe) begin
          shift_d  = {dat_sync_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (strobe) begin
          par_d   = dat_sync_q;
          state_d = STOP;
        end
      end
      STOP: begin
        if (strobe) begin
          state_d = IDLE;
          if ((^{shift_q, par_q}) && dat_sync_q) begin
            valid_d = 1'b1;
            code_d  = shift_q;
            if (shift_q == 8'hE0) begin
              ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
              brk_d = 1'b1;
            end else begin
              case ({ext_q, shift_q})
                9'h01D: key_mask = 10'b00000_00001;
                9'h01B: key_mask = 10'b00000_00010;
                9'h01C: key_mask = 10'b00000_00100;
                9'h023: key_mask = 10'b00000_01000;
                9'h029: key_mask = 10'b00000_10000;
                9'h05A: key_mask = 10'b10000_00000;
                9'h175: key_mask = 10'b00001_00000;
                9'h172: key_mask = 10'b00010_00000;
                9'h16B: key_mask = 10'b00100_00000;
                9'h174: key_mask = 10'b01000_00000;
                9'h15A: key_mask = 10'b10000_00000;
                default: key_mask = '0;
              endcase
              keys_d = brk_q ? (keys_q & ~key_mask) : (keys_q | key_mask);
              ext_d  = 1'b0;
              brk_d  = 1'b0;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Mid-frame watchdog; prefix flags deliberately survive an abort.
    if (state_q != IDLE) begin
      if (strobe) begin
        tcnt_d = '0;
      end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
        state_d = IDLE;
        err_d   = 1'b1;
        tcnt_d  = '0;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tcnt_q     <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      keys_q     <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_meta_q <= clk_meta_d;
      clk_sync_q <= clk_sync_d;
      dat_meta_q <= dat_meta_d;
      dat_sync_q <= dat_sync_d;
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tcnt_q     <= tcnt_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      keys_q     <= keys_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign {o_p2_fire, o_p2_right, o_p2_left, o_p2_down, o_p2_up,
          o_p1_fire, o_p1_right, o_p1_left, o_p1_down, o_p1_up} = keys_q;
  assign o_scan_code  = code_q;
  assign o_scan_valid = valid_q;
  assign o_frame_err  = err_q;
endmodule

// File: tb/tb_ps2_key_mapper.sv
// tb/tb_ps2_key_mapper.sv - scoreboard bench for ps2_key_mapper with a key-table reference model
module tb_ps2_key_mapper;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;
  logic p1_up, p1_down, p1_left, p1_right, p1_fire;
  logic p2_up, p2_down, p2_left, p2_right, p2_fire;
  logic [7:0] scan_code;
  logic scan_valid, frame_err;

  ps2_key_mapper #(.FILTER_LEN(8), .TIMEOUT(50000)) dut (
    .clk(clk), .rst_n(rst_n), .i_ps2_clk(ps2_clk), .i_ps2_dat(ps2_dat),
    .o_p1_up(p1_up), .o_p1_down(p1_down), .o_p1_left(p1_left),
    .o_p1_right(p1_right), .o_p1_fire(p1_fire),
    .o_p2_up(p2_up), .o_p2_down(p2_down), .o_p2_left(p2_left),
    .o_p2_right(p2_right), .o_p2_fire(p2_fire),
    .o_scan_code(scan_code), .o_scan_valid(scan_valid), .o_frame_err(frame_err)
  );

  always #20 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
    logic [9:0] keys;
  } exp_t;

  typedef struct {
    bit       ext;
    bit [7:0] code;
    int       idx;
  } map_t;

  exp_t exp_q[$];
  map_t key_map[11];
  bit   m_held[10];
  bit   m_ext, m_brk;
  int   n_checks = 0;
  int   n_pass = 0;

  // Key index: 0..4 = P1 up/down/left/right/fire, 5..9 = P2 up/down/left/right/fire.
  function automatic logic [9:0] dut_keys();
    return {p2_fire, p2_right, p2_left, p2_down, p2_up,
            p1_fire, p1_right, p1_left, p1_down, p1_up};
  endfunction

  function automatic logic [9:0] model_keys();
    logic [9:0] v;
    for (int i = 0; i < 10; i++) v[i] = m_held[i];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 10; i++) m_held[i] = 1'b0;
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  task automatic model_frame(input bit [7:0] b, input bit good);
    exp_t e;
    if (good) begin
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
        foreach (key_map[i])
          if (key_map[i].ext == m_ext && key_map[i].code == b) m_held[key_map[i].idx] = !m_brk;
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end
    e.is_err = !good;
    e.code   = b;
    e.keys   = model_keys();
    exp_q.push_back(e);
  endtask

  task automatic ps2_bit(input bit v);
    ps2_dat = v;
    repeat (15) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (30) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (15) @(posedge clk);
  endtask

  task automatic send(input bit [7:0] b, input bit bad_par = 0, input bit bad_stop = 0);
    model_frame(b, !(bad_par || bad_stop));
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(!bad_stop);
    ps2_dat = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (scan_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {scan_valid, frame_err}, 0);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", {scan_valid, frame_err}, e.is_err ? 2'b01 : 2'b10);
          if (!e.is_err) check("scan_code", scan_code, e.code);
          check("keys", dut_keys(), e.keys);
        end
      end
    end
  end

  initial begin
    bit [7:0] pool[16] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h5A, 8'h75, 8'h72,
                           8'h6B, 8'h74, 8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h11, 8'h2A};
    key_map[0]  = '{1'b0, 8'h1D, 0};
    key_map[1]  = '{1'b0, 8'h1B, 1};
    key_map[2]  = '{1'b0, 8'h1C, 2};
    key_map[3]  = '{1'b0, 8'h23, 3};
    key_map[4]  = '{1'b0, 8'h29, 4};
    key_map[5]  = '{1'b0, 8'h5A, 9};
    key_map[6]  = '{1'b1, 8'h75, 5};
    key_map[7]  = '{1'b1, 8'h72, 6};
    key_map[8]  = '{1'b1, 8'h6B, 7};
    key_map[9]  = '{1'b1, 8'h74, 8};
    key_map[10] = '{1'b1, 8'h5A, 9};
    model_reset();

    repeat (5) @(posedge clk);
    #1;
    check("reset_outputs", {dut_keys(), scan_code, scan_valid, frame_err}, 0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);

    send(8'h1D); send(8'hF0); send(8'h1D);
    drain();
    check("scan_code_final_1d", scan_code, 8'h1D);

    send(8'hE0); send(8'h75); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    drain();

    send(8'h29, 1'b1);
    send(8'h29);
    drain();
    check("p1_fire_after_good", p1_fire, 1'b1);

    // Short clock glitch while idle must be filtered out entirely.
    ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("glitch_keys", dut_keys(), model_keys());
    check("glitch_queue", exp_q.size(), 0);

    send(8'h1D); send(8'h1C); send(8'h29); send(8'hE0); send(8'h72);
    drain();
    #1;
    check("combo_held", {p1_up, p1_left, p1_fire, p2_down}, 4'hF);

    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    #7;
    rst_n = 1'b0;
    #1;
    check("async_reset", {dut_keys(), scan_code, scan_valid, frame_err}, 0);
    model_reset();
    ps2_dat = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    send(8'h1B);
    drain();
    check("post_reset_p1_down", p1_down, 1'b1);

    for (int i = 0; i < 26; i++) begin
      int r = $urandom_range(0, 5);
      send(pool[$urandom_range(0, 15)], r == 0, r == 1);
    end
    drain();

    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
    begin
      exp_t e;
      e.is_err = 1'b1;
      e.code   = 8'h00;
      e.keys   = model_keys();
      exp_q.push_back(e);
    end
    repeat (50100) @(posedge clk);
    check("timeout_seen", exp_q.size(), 0);
    send(8'h23);
    drain();
    check("p1_right_after_timeout", p1_right, 1'b1);

    repeat (20) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
